// File: rtl/enemy_pkg.sv
// Shared types, width helpers and default timing for the enemy life manager.
package enemy_pkg;

    // Life cycle of one enemy slot.
    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HIT   = 2'd1,
        DYING = 2'd2,
        DEAD  = 2'd3
    } enemy_state_t;

    // Default slot count and timing, in Frame_tick units.
    localparam int DEF_NUM_ENEMIES    = 5;
    localparam int DEF_ENEMY_HP       = 3;
    localparam int DEF_IFRAMES        = 30;
    localparam int DEF_DEATH_FRAMES   = 16;
    localparam int DEF_RESPAWN_FRAMES = 120;

    // Bits needed to hold 0..hp.
    function automatic int hp_width(input int hp);
        return $clog2(hp + 1);
    endfunction

    // Bits needed to hold the longest of the three timed windows.
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/enemy_life_fsm.sv
// Life cycle of a single enemy: hit points, invulnerability, death animation,
// respawn countdown, and the registered status/event outputs for that slot.
module enemy_life_fsm
    import enemy_pkg::*;
#(
    parameter int ENEMY_HP       = DEF_ENEMY_HP,
    parameter int IFRAMES        = DEF_IFRAMES,
    parameter int DEATH_FRAMES   = DEF_DEATH_FRAMES,
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
    parameter int HP_W           = hp_width(ENEMY_HP),
    parameter int TMR_W          = tmr_width(IFRAMES, DEATH_FRAMES, RESPAWN_FRAMES)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            tick_i,
    input  logic            hit_i,
    output logic            alive_o,
    output logic            flash_o,
    output logic [HP_W-1:0] hp_o,
    output logic            kill_o,
    output logic            respawn_o
);

    localparam logic [HP_W-1:0]  HP_FULL   = HP_W'(ENEMY_HP);
    localparam logic [HP_W-1:0]  HP_ONE    = HP_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_IFR   = TMR_W'(IFRAMES);
    localparam logic [TMR_W-1:0] TMR_DEATH = TMR_W'(DEATH_FRAMES);
    localparam logic [TMR_W-1:0] TMR_RESP  = TMR_W'(RESPAWN_FRAMES);

    enemy_state_t     state_q;
    logic [HP_W-1:0]  hp_q;
    logic [TMR_W-1:0] tmr_q;
    logic             alive_q;
    logic             flash_q;
    logic             kill_q;
    logic             respawn_q;

    // Hit flash blinks with bit 2 of the invulnerability countdown.
    function automatic logic blink(input logic [TMR_W-1:0] t);
        return |(t & TMR_W'(4));
    endfunction

    // Whole per-enemy state machine; status outputs are registered alongside
    // the state so they always describe the state just entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ALIVE;
            hp_q      <= HP_FULL;
            tmr_q     <= '0;
            alive_q   <= 1'b1;
            flash_q   <= 1'b0;
            kill_q    <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            kill_q    <= 1'b0;
            respawn_q <= 1'b0;
            if (clear_i) begin
                state_q <= ALIVE;
                hp_q    <= HP_FULL;
                tmr_q   <= '0;
                alive_q <= 1'b1;
                flash_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ALIVE: begin
                        // A hit beats a same-cycle tick; the tick is simply not counted.
                        if (hit_i) begin
                            if (hp_q > HP_ONE) begin
                                hp_q    <= hp_q - HP_ONE;
                                tmr_q   <= TMR_IFR;
                                state_q <= HIT;
                                alive_q <= 1'b1;
                                flash_q <= blink(TMR_IFR);
                            end else begin
                                hp_q    <= '0;
                                tmr_q   <= TMR_DEATH;
                                state_q <= DYING;
                                alive_q <= 1'b0;
                                flash_q <= 1'b1;
                                kill_q  <= 1'b1;
                            end
                        end
                    end
                    HIT: begin
                        if (tick_i) begin
                            if (tmr_q == TMR_ONE) begin
                                tmr_q   <= '0;
                                state_q <= ALIVE;
                                flash_q <= 1'b0;
                            end else if (tmr_q != '0) begin
                                tmr_q   <= tmr_q - TMR_ONE;
                                flash_q <= blink(tmr_q - TMR_ONE);
                            end
                        end
                    end
                    DYING: begin
                        if (tick_i) begin
                            if (tmr_q == TMR_ONE) begin
                                tmr_q   <= TMR_RESP;
                                state_q <= DEAD;
                                flash_q <= 1'b0;
                            end else if (tmr_q != '0) begin
                                tmr_q <= tmr_q - TMR_ONE;
                            end
                        end
                    end
                    DEAD: begin
                        if (tick_i) begin
                            if (tmr_q == TMR_ONE) begin
                                tmr_q     <= '0;
                                hp_q      <= HP_FULL;
                                state_q   <= ALIVE;
                                alive_q   <= 1'b1;
                                respawn_q <= 1'b1;
                            end else if (tmr_q != '0) begin
                                tmr_q <= tmr_q - TMR_ONE;
                            end
                        end
                    end
                    default: begin
                        state_q <= ALIVE;
                    end
                endcase
            end
        end
    end

    assign alive_o   = alive_q;
    assign flash_o   = flash_q;
    assign hp_o      = hp_q;
    assign kill_o    = kill_q;
    assign respawn_o = respawn_q;

endmodule

// File: rtl/enemy_life_manager.sv
// Receiver of per-enemy damage strobes: detects rising edges, runs one life
// FSM per enemy and packs their status/event outputs for renderer and score.
module enemy_life_manager
    import enemy_pkg::*;
#(
    parameter int NUM_ENEMIES    = DEF_NUM_ENEMIES,
    parameter int ENEMY_HP       = DEF_ENEMY_HP,
    parameter int IFRAMES        = DEF_IFRAMES,
    parameter int DEATH_FRAMES   = DEF_DEATH_FRAMES,
    parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
    input  logic                                       Clk,
    input  logic                                       Reset_n,
    input  logic                                       Frame_tick,
    input  logic                                       Game_over,
    input  logic [NUM_ENEMIES-1:0]                     Damage_E,
    output logic [NUM_ENEMIES-1:0]                     Enemy_alive,
    output logic [NUM_ENEMIES-1:0]                     Enemy_flash,
    output logic [NUM_ENEMIES*hp_width(ENEMY_HP)-1:0]  Enemy_hp,
    output logic [NUM_ENEMIES-1:0]                     Kill_mask,
    output logic [NUM_ENEMIES-1:0]                     Respawn
);

    localparam int HP_W  = hp_width(ENEMY_HP);
    localparam int TMR_W = tmr_width(IFRAMES, DEATH_FRAMES, RESPAWN_FRAMES);

    // Zero-length windows or zero hit points have no meaningful behaviour.
    if (NUM_ENEMIES < 1 || ENEMY_HP < 1 || IFRAMES < 1 ||
        DEATH_FRAMES < 1 || RESPAWN_FRAMES < 1) begin : g_bad_param
        $error("enemy_life_manager: parameters must all be at least 1");
    end

    logic [NUM_ENEMIES-1:0] damage_prev_q;
    logic [NUM_ENEMIES-1:0] hit;

    // Previous damage level, tracked every cycle (also during Game_over, so a
    // level held across the clear is not seen as a fresh hit afterwards).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            damage_prev_q <= '0;
        end else begin
            damage_prev_q <= Damage_E;
        end
    end

    assign hit = Damage_E & ~damage_prev_q;

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_enemy
        enemy_life_fsm #(
            .ENEMY_HP       (ENEMY_HP),
            .IFRAMES        (IFRAMES),
            .DEATH_FRAMES   (DEATH_FRAMES),
            .RESPAWN_FRAMES (RESPAWN_FRAMES),
            .HP_W           (HP_W),
            .TMR_W          (TMR_W)
        ) u_fsm (
            .clk_i     (Clk),
            .rst_ni    (Reset_n),
            .clear_i   (Game_over),
            .tick_i    (Frame_tick),
            .hit_i     (hit[i]),
            .alive_o   (Enemy_alive[i]),
            .flash_o   (Enemy_flash[i]),
            .hp_o      (Enemy_hp[i*HP_W +: HP_W]),
            .kill_o    (Kill_mask[i]),
            .respawn_o (Respawn[i])
        );
    end

endmodule
